bsub16_pipe: RTL
================

BSUB16_PIPE -- requirements
Module: bsub16_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand width; only 16 is supported.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-004 SHALL have port a, input, 16, the minuend (unsigned).
REQ-005 SHALL have port b, input, 16, the subtrahend (unsigned).
REQ-006 SHALL have port in_valid, input, 1; a and b are valid this cycle.
REQ-007 SHALL have port in_ready, output, 1; the block accepts a and b this cycle.
REQ-008 SHALL have port diff, output, 16, the result (a - b) mod 2^16.
REQ-009 SHALL have port borrow, output, 1; 1 when a < b (unsigned).
REQ-010 SHALL have port out_valid, output, 1; diff and borrow are valid.
REQ-011 SHALL have port out_ready, input, 1; the downstream consumer accepts the result this cycle.

Function
REQ-012 SHALL compute a + ~b + 1 with carry-in fixed at 1, folded into bit 0 as g0' = g0 | p0, where p = a ^ ~b and g = a & ~b.
REQ-013 SHALL resolve carries with a Brent-Kung prefix tree; no ripple chain and no behavioural "-" operator on the datapath.
REQ-014 SHALL form a two-stage pipeline:
- stage 1 registers p, g and the up-sweep group (P,G) terms for spans 2, 4, 8 and 16;
- stage 2 performs the down-sweep, then registers diff[i] = p[i] ^ c[i] and borrow = ~c[16].
REQ-015 SHALL carry one valid bit per stage (v1, v2); out_valid = v2.
REQ-016 SHALL advance stage 2 when (~v2 | out_ready), and stage 1 when (~v1 | stage 2 advances).
REQ-017 SHALL drive in_ready = ~v1 | (~v2 | out_ready); in_ready is combinational, and no combinational path exists from in_valid to in_ready.
REQ-018 SHALL give latency 2 cycles: a transfer at edge N yields out_valid at edge N+2 when there are no stalls.
REQ-019 SHALL sustain throughput of one result per cycle while out_ready = 1.
REQ-020 SHALL, while out_valid = 1 and out_ready = 0, hold diff, borrow and out_valid stable.
REQ-021 SHALL, when stalled, hold at most two results in flight (one per stage), and deassert in_ready only when both stages are full and out_ready = 0.
REQ-022 SHALL, when the output is consumed and a new input arrives in the same cycle, accept both with no bubble.
REQ-023 SHALL deliver results in acceptance order; no loss or duplication.
REQ-024 SHALL ignore a and b when in_valid = 0 or in_ready = 0, and load no stage data registers.
REQ-025 SHALL meet these arithmetic boundaries:
- a = b gives diff 0, borrow 0;
- b = 0 gives diff = a, borrow 0;
- a = 0, b ≠ 0 gives diff = 2^16 - b, borrow 1.

Reset
REQ-026 SHALL, when rst_n = 0 at a clock edge, clear v1, v2, diff, borrow and all stage registers to 0.
REQ-027 SHALL drive out_valid = 0 and in_ready = 1 during reset and in the first cycle after rst_n rises.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no result emerges after release unless new input is accepted.

Verification
REQ-029 SHALL cover single op: a=0x0005, b=0x0003, out_ready=1 -> two edges later out_valid=1, diff=0x0002, borrow=0.
REQ-030 SHALL cover wrap: a=0x0000, b=0x0001 -> diff=0xFFFF, borrow=1; a=0x8000, b=0x8000 -> diff=0x0000, borrow=0; a=0xFFFF, b=0x0000 -> diff=0xFFFF, borrow=0.
REQ-031 SHALL cover streaming: 4 back-to-back ops (0x0010-0x0001, 0x1234-0x0234, 0x0001-0x0002, 0xFFFF-0xFFFF) with out_ready=1 -> 0x000F/0, 0x1000/0, 0xFFFF/1, 0x0000/0 on 4 consecutive cycles.
REQ-032 SHALL cover backpressure: out_ready=0 for 4 cycles while in_valid=1 with 3 ops -> 2 accepted, in_ready=0 from third offer, first result held stable; after out_ready=1, all 3 results emerge in order.
REQ-033 SHALL cover reset mid-op: accept 2 ops, assert rst_n=0 one cycle, release -> out_valid stays 0, in_ready=1, next op a=0x0100, b=0x0001 -> diff=0x00FF after 2 cycles.
REQ-034 SHALL cover randomized: 10^5 random a, b with random in_valid/out_ready -> every result matches the reference model (a-b mod 2^16, a<b), order preserved, zero mismatches.

Source files
------------

// File: rtl/bsub16_pipe.sv
// bsub16_pipe -- two-stage pipelined 16-bit unsigned subtractor.
//
// The difference a - b is formed as a + ~b + 1. The +1 carry-in is folded into
// bit 0 of the generate vector, so the prefix tree needs no separate carry-in.
// Carries are resolved by a Brent-Kung prefix tree:
//   stage 1 : bitwise p/g plus the up-sweep group terms (spans 2, 4, 8, 16), registered
//   stage 2 : down-sweep to fill in the remaining prefixes, then diff/borrow registered
// Each stage has a valid bit. A stage can take new data when it is empty or when
// the stage after it is moving on. This gives one result per cycle with no bubbles.
//
// Ports
//   clk        : clock; all state changes on its rising edge
//   rst_n      : synchronous active-low reset
//   a, b       : unsigned minuend / subtrahend
//   in_valid   : a/b valid this cycle
//   in_ready   : block accepts a/b this cycle (never depends on in_valid)
//   diff       : (a - b) mod 2^16
//   borrow     : 1 when a < b
//   out_valid  : diff/borrow valid
//   out_ready  : consumer takes diff/borrow this cycle
//
// The prefix tree is written for WIDTH = 16 only.

module bsub16_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             out_valid,
    input  logic             out_ready
);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic v1_reg;
    logic v2_reg;
    logic adv1;
    logic adv2;

    assign adv2      = ~v2_reg | out_ready;
    assign adv1      = ~v1_reg | adv2;
    assign in_ready  = adv1;
    assign out_valid = v2_reg;

    // ------------------------------------------------------------------
    // Stage 1 combinational: bitwise propagate/generate and up-sweep
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] nb;
    logic [WIDTH-1:0] p_next;
    logic [WIDTH-1:0] g_raw;
    logic [WIDTH-1:0] g_next;

    assign nb     = ~b;
    assign p_next = a ^ nb;
    assign g_raw  = a & nb;
    // With carry-in = 1, bit 0 generates whenever it generates or propagates.
    assign g_next = {g_raw[WIDTH-1:1], g_raw[0] | p_next[0]};

    // Group (G,P) terms. Bit i of grpN covers bits [i-N+1 : i]. Only the
    // tree nodes (i+1 a multiple of N) are real; other bits are tied to 0.
    logic [WIDTH-1:0] grp2_g_next,  grp2_p_next;
    logic [WIDTH-1:0] grp4_g_next,  grp4_p_next;
    logic [WIDTH-1:0] grp8_g_next,  grp8_p_next;
    logic [WIDTH-1:0] grp16_g_next, grp16_p_next;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_up
            if (gi % 2 == 1) begin : g_s2
                assign grp2_g_next[gi] = g_next[gi] | (p_next[gi] & g_next[gi-1]);
                assign grp2_p_next[gi] = p_next[gi] & p_next[gi-1];
            end else begin : g_s2_z
                assign grp2_g_next[gi] = 1'b0;
                assign grp2_p_next[gi] = 1'b0;
            end

            if (gi % 4 == 3) begin : g_s4
                assign grp4_g_next[gi] = grp2_g_next[gi] | (grp2_p_next[gi] & grp2_g_next[gi-2]);
                assign grp4_p_next[gi] = grp2_p_next[gi] & grp2_p_next[gi-2];
            end else begin : g_s4_z
                assign grp4_g_next[gi] = 1'b0;
                assign grp4_p_next[gi] = 1'b0;
            end

            if (gi % 8 == 7) begin : g_s8
                assign grp8_g_next[gi] = grp4_g_next[gi] | (grp4_p_next[gi] & grp4_g_next[gi-4]);
                assign grp8_p_next[gi] = grp4_p_next[gi] & grp4_p_next[gi-4];
            end else begin : g_s8_z
                assign grp8_g_next[gi] = 1'b0;
                assign grp8_p_next[gi] = 1'b0;
            end

            if (gi % 16 == 15) begin : g_s16
                assign grp16_g_next[gi] = grp8_g_next[gi] | (grp8_p_next[gi] & grp8_g_next[gi-8]);
                assign grp16_p_next[gi] = grp8_p_next[gi] & grp8_p_next[gi-8];
            end else begin : g_s16_z
                assign grp16_g_next[gi] = 1'b0;
                assign grp16_p_next[gi] = 1'b0;
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] s1_p_reg,      s1_g_reg;
    logic [WIDTH-1:0] s1_grp2_g_reg,  s1_grp2_p_reg;
    logic [WIDTH-1:0] s1_grp4_g_reg,  s1_grp4_p_reg;
    logic [WIDTH-1:0] s1_grp8_g_reg,  s1_grp8_p_reg;
    logic [WIDTH-1:0] s1_grp16_g_reg, s1_grp16_p_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_reg         <= 1'b0;
            s1_p_reg       <= '0;
            s1_g_reg       <= '0;
            s1_grp2_g_reg  <= '0;
            s1_grp2_p_reg  <= '0;
            s1_grp4_g_reg  <= '0;
            s1_grp4_p_reg  <= '0;
            s1_grp8_g_reg  <= '0;
            s1_grp8_p_reg  <= '0;
            s1_grp16_g_reg <= '0;
            s1_grp16_p_reg <= '0;
        end else begin
            if (adv1) begin
                v1_reg <= in_valid;
            end
            // Data registers load only on an actual transfer.
            if (adv1 && in_valid) begin
                s1_p_reg       <= p_next;
                s1_g_reg       <= g_next;
                s1_grp2_g_reg  <= grp2_g_next;
                s1_grp2_p_reg  <= grp2_p_next;
                s1_grp4_g_reg  <= grp4_g_next;
                s1_grp4_p_reg  <= grp4_p_next;
                s1_grp8_g_reg  <= grp8_g_next;
                s1_grp8_p_reg  <= grp8_p_next;
                s1_grp16_g_reg <= grp16_g_next;
                s1_grp16_p_reg <= grp16_p_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: Brent-Kung down-sweep
    // ------------------------------------------------------------------
    // pre_g[i] = group generate over bits [i:0] (carry-in already folded in),
    // which is the carry out of bit i.
    // The up-sweep already gives the prefixes at bits 0, 1, 3, 7 and 15.
    logic             pre_11;
    logic [WIDTH-1:0] pre_odd;
    logic [WIDTH-1:0] pre_g;

    // Distance-4 step: bit 11.
    assign pre_11 = s1_grp4_g_reg[11] | (s1_grp4_p_reg[11] & s1_grp8_g_reg[7]);

    // Bit 0 and all odd-bit prefixes; even bits 2..14 come one level later.
    always_comb begin
        pre_odd     = '0;
        pre_odd[0]  = s1_g_reg[0];
        pre_odd[1]  = s1_grp2_g_reg[1];
        pre_odd[3]  = s1_grp4_g_reg[3];
        pre_odd[7]  = s1_grp8_g_reg[7];
        pre_odd[15] = s1_grp16_g_reg[15];
        pre_odd[11] = pre_11;
        // Distance-2 step: bits 5, 9, 13.
        pre_odd[5]  = s1_grp2_g_reg[5]  | (s1_grp2_p_reg[5]  & s1_grp4_g_reg[3]);
        pre_odd[9]  = s1_grp2_g_reg[9]  | (s1_grp2_p_reg[9]  & s1_grp8_g_reg[7]);
        pre_odd[13] = s1_grp2_g_reg[13] | (s1_grp2_p_reg[13] & pre_11);
    end

    // Distance-1 step: each even bit joins the prefix of the bit below it.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_dn
            if ((gi % 2 == 0) && (gi != 0)) begin : g_even
                assign pre_g[gi] = s1_g_reg[gi] | (s1_p_reg[gi] & pre_odd[gi-1]);
            end else begin : g_odd
                assign pre_g[gi] = pre_odd[gi];
            end
        end
    endgenerate

    // Carry into bit 0 is the folded-in 1. Carry into bit i is pre_g[i-1].
    logic [WIDTH-1:0] diff_next;
    logic             borrow_next;

    assign diff_next   = s1_p_reg ^ {pre_g[WIDTH-2:0], 1'b1};
    assign borrow_next = ~pre_g[WIDTH-1];

    // Some stored group bits are only consumed inside stage 1. They are
    // registered so the stage boundary holds the complete up-sweep result.
    logic unused_s1;
    assign unused_s1 = ^{s1_g_reg, s1_grp2_g_reg, s1_grp2_p_reg,
                         s1_grp4_g_reg, s1_grp4_p_reg,
                         s1_grp8_g_reg, s1_grp8_p_reg,
                         s1_grp16_g_reg, s1_grp16_p_reg, pre_odd};

    // ------------------------------------------------------------------
    // Stage 2 registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] diff_reg;
    logic             borrow_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2_reg     <= 1'b0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
        end else begin
            if (adv2) begin
                v2_reg <= v1_reg;
            end
            if (adv2 && v1_reg) begin
                diff_reg   <= diff_next;
                borrow_reg <= borrow_next;
            end
        end
    end

    assign diff   = diff_reg;
    assign borrow = borrow_reg;

endmodule
